// File: rtl/cpu_pkg.sv
// Shared constants for the 18-bit CPU front end: datapath widths, reset PC and
// the encoding of the fetch state machine.
package cpu_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int INST_WIDTH = 18;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t FETCH = 2'd1;
    localparam fetch_state_t HOLD  = 2'd2;
    localparam fetch_state_t DROP  = 2'd3;

endpackage

// File: rtl/pc_register.sv
// Program counter with priority clear > load > increment; wraps modulo 2^ADDR_WIDTH.
// pc_next_o exposes the value the register takes at the coming edge.
module pc_register
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_next_o
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clear_i)
            pc_d = RESET_PC;
        else if (load_i)
            pc_d = load_addr_i;
        else if (inc_i)
            pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding memory request, a one-word instruction buffer
// toward decode, and redirect/clearPC handling that discards stale replies.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int                    INST_WIDTH = cpu_pkg::INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic                  clock,
    input  logic                  resetFetchUnit,
    input  logic                  clearPC,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemValid,
    input  logic [INST_WIDTH-1:0] imemData,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectAddr,
    output logic                  instValid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instPC,
    input  logic                  instReady
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  imemReq_q, imemReq_d;
    logic [ADDR_WIDTH-1:0] imemAddr_q, imemAddr_d;
    logic                  instValid_q, instValid_d;
    logic [INST_WIDTH-1:0] instruction_q, instruction_d;
    logic [ADDR_WIDTH-1:0] instPC_q, instPC_d;

    logic redir;
    logic accept;

    assign redir  = clearPC | redirect;
    assign accept = (state_q == FETCH) && imemValid;

    // A word returning in a redirect cycle is stale, so the PC must not advance past it.
    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk_i       (clock),
        .rst_i       (resetFetchUnit),
        .clear_i     (clearPC),
        .load_i      (redirect),
        .load_addr_i (redirectAddr),
        .inc_i       (accept),
        .pc_o        (pc_q),
        .pc_next_o   (pc_d)
    );

    always_ff @(posedge clock or posedge resetFetchUnit) begin
        if (resetFetchUnit) begin
            state_q       <= IDLE;
            imemReq_q     <= 1'b0;
            imemAddr_q    <= RESET_PC;
            instValid_q   <= 1'b0;
            instruction_q <= '0;
            instPC_q      <= '0;
        end else begin
            state_q       <= state_d;
            imemReq_q     <= imemReq_d;
            imemAddr_q    <= imemAddr_d;
            instValid_q   <= instValid_d;
            instruction_q <= instruction_d;
            instPC_q      <= instPC_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imemValid)
                    state_d = redir ? FETCH : HOLD;
                else if (redir)
                    state_d = DROP;
            end
            HOLD: begin
                if (redir || (instValid_q && instReady))
                    state_d = FETCH;
            end
            DROP: begin
                // The outstanding reply must be absorbed even if redirected again.
                if (imemValid)
                    state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imemReq_d     = (state_d == FETCH);
        imemAddr_d    = (state_d == FETCH) ? pc_d : imemAddr_q;
        instValid_d   = instValid_q;
        instruction_d = instruction_q;
        instPC_d      = instPC_q;
        if (state_q == HOLD && instValid_q && instReady)
            instValid_d = 1'b0;
        if (accept && !redir) begin
            instValid_d   = 1'b1;
            instruction_d = imemData;
            instPC_d      = pc_q;
        end
        if (redir)
            instValid_d = 1'b0;
    end

    assign imemReq     = imemReq_q;
    assign imemAddr    = imemAddr_q;
    assign instValid   = instValid_q;
    assign instruction = instruction_q;
    assign instPC      = instPC_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit: the testbench plays instruction memory by
// hand, pulsing imemValid at chosen cycles, and checks outputs #1 after each edge.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        resetFetchUnit;
    logic        clearPC;
    logic        imemReq;
    logic [13:0] imemAddr;
    logic        imemValid;
    logic [17:0] imemData;
    logic        redirect;
    logic [13:0] redirectAddr;
    logic        instValid;
    logic [17:0] instruction;
    logic [13:0] instPC;
    logic        instReady;

    int tests  = 0;
    int failed = 0;

    instruction_fetch_unit dut (
        .clock          (clock),
        .resetFetchUnit (resetFetchUnit),
        .clearPC        (clearPC),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemValid      (imemValid),
        .imemData       (imemData),
        .redirect       (redirect),
        .redirectAddr   (redirectAddr),
        .instValid      (instValid),
        .instruction    (instruction),
        .instPC         (instPC),
        .instReady      (instReady)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetFetchUnit = 1'b1; clearPC = 1'b0; imemValid = 1'b0; imemData = '0;
        redirect = 1'b0; redirectAddr = '0; instReady = 1'b0;
        tick(); tick();
        tests++; if (imemReq !== 1'b0) begin failed++; $display("FAIL reset_req got %b exp 0", imemReq); end
        tests++; if (imemAddr !== 14'h0) begin failed++; $display("FAIL reset_addr got %h exp 0000", imemAddr); end
        tests++; if (instValid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", instValid); end
        tests++; if (instruction !== 18'h0 || instPC !== 14'h0) begin failed++; $display("FAIL reset_buf got %h/%h exp 0/0", instruction, instPC); end
        resetFetchUnit = 1'b0;
        tick();
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h0) begin failed++; $display("FAIL first_req got %b@%h exp 1@0000", imemReq, imemAddr); end
    endtask

    task automatic test_first_fetch();
        imemValid = 1'b1; imemData = 18'h2A5F3;
        tick();
        imemValid = 1'b0;
        tests++; if (instValid !== 1'b1) begin failed++; $display("FAIL t1_valid got %b exp 1", instValid); end
        tests++; if (instruction !== 18'h2A5F3) begin failed++; $display("FAIL t1_inst got %h exp 2a5f3", instruction); end
        tests++; if (instPC !== 14'h0 || imemReq !== 1'b0) begin failed++; $display("FAIL t1_pc_req got %h/%b exp 0000/0", instPC, imemReq); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (instValid !== 1'b1 || instruction !== 18'h2A5F3 || instPC !== 14'h0 || imemReq !== 1'b0) begin
                failed++;
                $display("FAIL t2_stall%0d got v=%b i=%h pc=%h req=%b exp 1/2a5f3/0000/0", i, instValid, instruction, instPC, imemReq);
            end
        end
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h0001 || instValid !== 1'b0) begin failed++; $display("FAIL t2_next got %b@%h v=%b exp 1@0001 v=0", imemReq, imemAddr, instValid); end
    endtask

    // Serve fetches at 1..4 with immediate consumption so PC reaches 5.
    task automatic test_back_to_back();
        for (int a = 1; a < 5; a++) begin
            imemValid = 1'b1; imemData = 18'h10000 + 18'(a);
            tick();
            imemValid = 1'b0;
            tests++; if (instValid !== 1'b1 || instPC !== 14'(a) || instruction !== 18'h10000 + 18'(a)) begin failed++; $display("FAIL b2b_word%0d got v=%b pc=%h i=%h", a, instValid, instPC, instruction); end
            instReady = 1'b1;
            tick();
            instReady = 1'b0;
            tests++; if (imemReq !== 1'b1 || imemAddr !== 14'(a + 1)) begin failed++; $display("FAIL b2b_addr%0d got %b@%h exp 1@%h", a, imemReq, imemAddr, 14'(a + 1)); end
        end
    endtask

    task automatic test_redirect_drop();
        tick();
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h0005) begin failed++; $display("FAIL t3_pending got %b@%h exp 1@0005", imemReq, imemAddr); end
        redirect = 1'b1; redirectAddr = 14'h0100;
        tick();
        redirect = 1'b0;
        tests++; if (imemReq !== 1'b0 || instValid !== 1'b0) begin failed++; $display("FAIL t3_drop got req=%b v=%b exp 0/0", imemReq, instValid); end
        tick();
        imemValid = 1'b1; imemData = 18'h3DEAD;
        tick();
        imemValid = 1'b0;
        tests++; if (instValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 14'h0100) begin failed++; $display("FAIL t3_refetch got v=%b %b@%h exp 0 1@0100", instValid, imemReq, imemAddr); end
        imemValid = 1'b1; imemData = 18'h01234;
        tick();
        imemValid = 1'b0;
        tests++; if (instValid !== 1'b1 || instPC !== 14'h0100 || instruction !== 18'h01234) begin failed++; $display("FAIL t3_word got v=%b pc=%h i=%h exp 1/0100/01234", instValid, instPC, instruction); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirectAddr = 14'h3FFF;
        tick();
        redirect = 1'b0;
        tests++; if (instValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 14'h3FFF) begin failed++; $display("FAIL t4_hold_redir got v=%b %b@%h exp 0 1@3fff", instValid, imemReq, imemAddr); end
        imemValid = 1'b1; imemData = 18'h3FFFF;
        tick();
        imemValid = 1'b0;
        tests++; if (instPC !== 14'h3FFF || instValid !== 1'b1) begin failed++; $display("FAIL t4_pc got %h v=%b exp 3fff 1", instPC, instValid); end
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h0000) begin failed++; $display("FAIL t4_wrap got %b@%h exp 1@0000", imemReq, imemAddr); end
    endtask

    task automatic test_clear_priority();
        imemValid = 1'b1; imemData = 18'h00ABC;
        tick();
        imemValid = 1'b0;
        tests++; if (instValid !== 1'b1 || instPC !== 14'h0) begin failed++; $display("FAIL t5_word got v=%b pc=%h exp 1/0000", instValid, instPC); end
        clearPC = 1'b1; redirect = 1'b1; redirectAddr = 14'h0200;
        tick();
        clearPC = 1'b0; redirect = 1'b0;
        tests++; if (instValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 14'h0000) begin failed++; $display("FAIL t5_clear got v=%b %b@%h exp 0 1@0000", instValid, imemReq, imemAddr); end
    endtask

    task automatic test_redirect_with_valid();
        imemValid = 1'b1; imemData = 18'h15555; redirect = 1'b1; redirectAddr = 14'h00AB;
        tick();
        imemValid = 1'b0; redirect = 1'b0;
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h00AB) begin failed++; $display("FAIL rv_addr got %b@%h exp 1@00ab", imemReq, imemAddr); end
        tests++; if (instValid !== 1'b0 || instruction !== 18'h00ABC) begin failed++; $display("FAIL rv_discard got v=%b i=%h exp 0/00abc", instValid, instruction); end
    endtask

    task automatic test_async_reset();
        #2 resetFetchUnit = 1'b1;
        #1;
        tests++; if (imemReq !== 1'b0 || imemAddr !== 14'h0 || instValid !== 1'b0) begin failed++; $display("FAIL t6_ctrl got %b@%h v=%b exp 0@0000 v=0", imemReq, imemAddr, instValid); end
        tests++; if (instruction !== 18'h0 || instPC !== 14'h0) begin failed++; $display("FAIL t6_buf got %h/%h exp 0/0", instruction, instPC); end
        tick();
        resetFetchUnit = 1'b0;
        tick();
        tests++; if (imemReq !== 1'b1 || imemAddr !== 14'h0) begin failed++; $display("FAIL t6_restart got %b@%h exp 1@0000", imemReq, imemAddr); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_back_to_back();
        test_redirect_drop();
        test_wrap();
        test_clear_priority();
        test_redirect_with_valid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
